// File: rtl/toy_trap_ctrl.sv
// Trap/xret sequencer: captures a trap or return request, updates the machine/debug
// CSRs in one cycle, then holds a fetch redirect until the frontend accepts it.
package toy_pack;
  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam logic [4:0] MCAUSE_ILLEGAL_INSTR = 5'd2;
  localparam logic [4:0] MCAUSE_BREAK         = 5'd3;
  localparam logic [4:0] MCAUSE_ECALL_M       = 5'd11;
  localparam logic [5:0] DEBUG_HALT_REQ       = 6'h3F;
endpackage

module toy_trap_ctrl
  import toy_pack::*;
#(
  parameter logic [ADDR_WIDTH-1:0] DEBUG_ROM_BASE = 32'h0000_0800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spu_jump_vld,
  input  logic [1:0]            spu_jump_op,
  input  logic [5:0]            spu_trap_cause,
  input  logic [ADDR_WIDTH-1:0] spu_trap_pc,
  input  logic [INST_WIDTH-1:0] spu_trap_inst,
  input  logic                  spu_wfi_vld,
  input  logic                  irq_pending,
  input  logic [ADDR_WIDTH-1:0] csr_mtvec,
  input  logic [ADDR_WIDTH-1:0] csr_sepc,
  input  logic                  csr_wr_vld,
  input  logic [2:0]            csr_wr_sel,
  input  logic [31:0]           csr_wr_data,
  output logic                  redirect_vld,
  input  logic                  redirect_rdy,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  trap_busy,
  output logic                  wfi_sleep,
  output logic                  debug_mode,
  output logic [ADDR_WIDTH-1:0] csr_mepc,
  output logic [ADDR_WIDTH-1:0] csr_mtval,
  output logic [ADDR_WIDTH-1:0] csr_dpc,
  output logic [31:0]           csr_mcause,
  output logic                  csr_mstatus_mie,
  output logic                  csr_mstatus_mpie,
  output logic                  trap_drop_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_UPDATE   = 2'd1,
    S_REDIRECT = 2'd2,
    S_WFI      = 2'd3
  } state_t;

  localparam logic [1:0] OP_SRET = 2'b00;
  localparam logic [1:0] OP_MRET = 2'b01;
  localparam logic [1:0] OP_DRET = 2'b10;
  localparam logic [1:0] OP_TRAP = 2'b11;

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [5:0]              cause_q, cause_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic [ADDR_WIDTH-1:0]   mepc_q, mepc_d;
  logic [ADDR_WIDTH-1:0]   mtval_q, mtval_d;
  logic [ADDR_WIDTH-1:0]   dpc_q, dpc_d;
  logic [31:0]             mcause_q, mcause_d;
  logic                    mie_q, mie_d;
  logic                    mpie_q, mpie_d;
  logic                    debug_q, debug_d;
  logic [ADDR_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
  logic                    drop_err_q, drop_err_d;

  logic                    take_trap;
  logic                    dret_illegal;
  logic [5:0]              eff_cause;
  logic [ADDR_WIDTH-1:0]   tvec_base;
  logic [ADDR_WIDTH-1:0]   trap_tgt;

  // A dret outside debug mode is turned into an illegal-instruction trap.
  always_comb begin
    dret_illegal = (op_q == OP_DRET) && !debug_q;
    take_trap    = (op_q == OP_TRAP) || dret_illegal;
    eff_cause    = dret_illegal ? {1'b0, MCAUSE_ILLEGAL_INSTR} : cause_q;
    tvec_base    = {csr_mtvec[ADDR_WIDTH-1:2], 2'b00};
    if ((csr_mtvec[1:0] == 2'b01) && eff_cause[5])
      trap_tgt = tvec_base + (ADDR_WIDTH'(eff_cause[4:0]) << 2);
    else
      trap_tgt = tvec_base;
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cause_d       = cause_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    mepc_d        = mepc_q;
    mtval_d       = mtval_q;
    dpc_d         = dpc_q;
    mcause_d      = mcause_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    debug_d       = debug_q;
    redirect_pc_d = redirect_pc_q;
    drop_err_d    = drop_err_q;

    if ((state_q != S_IDLE) && (spu_jump_vld || spu_wfi_vld))
      drop_err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (spu_jump_vld) begin
          op_d    = spu_jump_op;
          cause_d = spu_trap_cause;
          pc_d    = spu_trap_pc;
          inst_d  = spu_trap_inst;
          state_d = S_UPDATE;
        end else if (spu_wfi_vld) begin
          state_d = S_WFI;
        end
        // mstatus write uses data[1]=MPIE, data[0]=MIE
        if (csr_wr_vld) begin
          unique case (csr_wr_sel)
            3'd0:    mepc_d   = ADDR_WIDTH'(csr_wr_data);
            3'd1:    mcause_d = csr_wr_data & 32'h8000_001F;
            3'd2:    mtval_d  = ADDR_WIDTH'(csr_wr_data);
            3'd3:    dpc_d    = ADDR_WIDTH'(csr_wr_data);
            3'd4:    {mpie_d, mie_d} = csr_wr_data[1:0];
            default: ;
          endcase
        end
      end
      S_UPDATE: begin
        state_d = S_REDIRECT;
        if (take_trap) begin
          if (debug_q) begin
            redirect_pc_d = DEBUG_ROM_BASE;
          end else if (eff_cause == DEBUG_HALT_REQ) begin
            dpc_d         = pc_q;
            debug_d       = 1'b1;
            redirect_pc_d = DEBUG_ROM_BASE;
          end else begin
            mepc_d   = pc_q;
            mcause_d = {eff_cause[5], 26'b0, eff_cause[4:0]};
            if (eff_cause[4:0] == MCAUSE_ILLEGAL_INSTR)
              mtval_d = ADDR_WIDTH'(inst_q);
            else if (eff_cause[4:0] == MCAUSE_BREAK)
              mtval_d = pc_q;
            else
              mtval_d = '0;
            mpie_d        = mie_q;
            mie_d         = 1'b0;
            redirect_pc_d = trap_tgt;
          end
        end else begin
          unique case (op_q)
            OP_MRET: begin
              mie_d         = mpie_q;
              mpie_d        = 1'b1;
              redirect_pc_d = mepc_q;
            end
            OP_DRET: begin
              debug_d       = 1'b0;
              redirect_pc_d = dpc_q;
            end
            default: redirect_pc_d = csr_sepc;
          endcase
        end
      end
      S_REDIRECT: begin
        if (redirect_rdy) state_d = S_IDLE;
      end
      S_WFI: begin
        if (irq_pending) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      cause_q       <= '0;
      pc_q          <= '0;
      inst_q        <= '0;
      mepc_q        <= '0;
      mtval_q       <= '0;
      dpc_q         <= '0;
      mcause_q      <= '0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      debug_q       <= 1'b0;
      redirect_pc_q <= '0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cause_q       <= cause_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      mepc_q        <= mepc_d;
      mtval_q       <= mtval_d;
      dpc_q         <= dpc_d;
      mcause_q      <= mcause_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      debug_q       <= debug_d;
      redirect_pc_q <= redirect_pc_d;
      drop_err_q    <= drop_err_d;
    end
  end

  assign redirect_vld     = (state_q == S_REDIRECT);
  assign redirect_pc      = redirect_pc_q;
  assign trap_busy        = (state_q != S_IDLE);
  assign wfi_sleep        = (state_q == S_WFI);
  assign debug_mode       = debug_q;
  assign csr_mepc         = mepc_q;
  assign csr_mtval        = mtval_q;
  assign csr_dpc          = dpc_q;
  assign csr_mcause       = mcause_q;
  assign csr_mstatus_mie  = mie_q;
  assign csr_mstatus_mpie = mpie_q;
  assign trap_drop_err    = drop_err_q;

endmodule

// File: tb/tb_toy_trap_ctrl.sv
// Bench for toy_trap_ctrl: directed scenarios plus randomized traps/returns checked
// against a transaction-level CSR model.
module tb_toy_trap_ctrl;
  import toy_pack::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spu_jump_vld = 0;
  logic [1:0]  spu_jump_op = 0;
  logic [5:0]  spu_trap_cause = 0;
  logic [31:0] spu_trap_pc = 0;
  logic [31:0] spu_trap_inst = 0;
  logic        spu_wfi_vld = 0;
  logic        irq_pending = 0;
  logic [31:0] csr_mtvec = 0;
  logic [31:0] csr_sepc = 0;
  logic        csr_wr_vld = 0;
  logic [2:0]  csr_wr_sel = 0;
  logic [31:0] csr_wr_data = 0;
  logic        redirect_vld;
  logic        redirect_rdy = 0;
  logic [31:0] redirect_pc;
  logic        trap_busy, wfi_sleep, debug_mode;
  logic [31:0] csr_mepc, csr_mtval, csr_dpc, csr_mcause;
  logic        csr_mstatus_mie, csr_mstatus_mpie, trap_drop_err;

  int errors = 0;
  int checks = 0;

  // transaction-level model of the architectural CSRs
  logic [31:0] m_mepc, m_mtval, m_dpc, m_mcause;
  logic        m_mie, m_mpie, m_dbg;

  toy_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .spu_jump_vld(spu_jump_vld), .spu_jump_op(spu_jump_op),
    .spu_trap_cause(spu_trap_cause), .spu_trap_pc(spu_trap_pc),
    .spu_trap_inst(spu_trap_inst), .spu_wfi_vld(spu_wfi_vld),
    .irq_pending(irq_pending), .csr_mtvec(csr_mtvec), .csr_sepc(csr_sepc),
    .csr_wr_vld(csr_wr_vld), .csr_wr_sel(csr_wr_sel), .csr_wr_data(csr_wr_data),
    .redirect_vld(redirect_vld), .redirect_rdy(redirect_rdy), .redirect_pc(redirect_pc),
    .trap_busy(trap_busy), .wfi_sleep(wfi_sleep), .debug_mode(debug_mode),
    .csr_mepc(csr_mepc), .csr_mtval(csr_mtval), .csr_dpc(csr_dpc),
    .csr_mcause(csr_mcause), .csr_mstatus_mie(csr_mstatus_mie),
    .csr_mstatus_mpie(csr_mstatus_mpie), .trap_drop_err(trap_drop_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mepc = 0; m_mtval = 0; m_dpc = 0; m_mcause = 0;
    m_mie = 0; m_mpie = 0; m_dbg = 0;
  endtask

  task automatic model_write(input logic [2:0] sel, input logic [31:0] d);
    case (sel)
      3'd0: m_mepc = d;
      3'd1: m_mcause = {d[31], 26'b0, d[4:0]};
      3'd2: m_mtval = d;
      3'd3: m_dpc = d;
      3'd4: begin m_mpie = d[1]; m_mie = d[0]; end
      default: ;
    endcase
  endtask

  // Applies one request to the model and returns where fetch must go next.
  task automatic model_req(input logic [1:0] op, input logic [5:0] cause,
                           input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] mtvec, input logic [31:0] sepc,
                           output logic [31:0] tgt);
    logic [31:0] base;
    int          code;
    bit          intr;
    base = mtvec & 32'hFFFF_FFFC;
    if (op == 2'b00) tgt = sepc;
    else if (op == 2'b01) begin
      tgt = m_mepc; m_mie = m_mpie; m_mpie = 1;
    end else if (op == 2'b10 && m_dbg) begin
      tgt = m_dpc; m_dbg = 0;
    end else if (m_dbg) tgt = 32'h800;
    else if (op == 2'b11 && cause == DEBUG_HALT_REQ) begin
      m_dpc = pc; m_dbg = 1; tgt = 32'h800;
    end else begin
      if (op == 2'b10) begin intr = 0; code = 2; end
      else begin intr = cause[5]; code = int'(cause[4:0]); end
      m_mepc = pc;
      m_mcause = intr ? (32'h8000_0000 + code) : code;
      m_mtval = (code == 2) ? inst : (code == 3) ? pc : 0;
      m_mpie = m_mie; m_mie = 0;
      tgt = (mtvec[1:0] == 2'b01 && intr) ? base + 4 * code : base;
    end
  endtask

  task automatic csr_write(input logic [2:0] sel, input logic [31:0] d);
    @(negedge clk);
    csr_wr_vld = 1; csr_wr_sel = sel; csr_wr_data = d;
    @(negedge clk);
    csr_wr_vld = 0;
  endtask

  // Drives one request and completes its redirect handshake; returns observations only.
  task automatic issue(input logic [1:0] op, input logic [5:0] cause, input logic [31:0] pc,
                       input logic [31:0] inst, input int rdy_delay,
                       output logic [31:0] got_pc, output int lat, output bit stable);
    @(negedge clk);
    spu_jump_vld = 1; spu_jump_op = op; spu_trap_cause = cause;
    spu_trap_pc = pc; spu_trap_inst = inst;
    lat = 0; stable = 1; got_pc = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      spu_jump_vld = 0;
      if (redirect_vld) begin lat = i; break; end
    end
    if (lat != 0) begin
      got_pc = redirect_pc;
      repeat (rdy_delay) begin
        @(negedge clk);
        if (redirect_pc !== got_pc || redirect_vld !== 1'b1) stable = 0;
      end
      redirect_rdy = 1;
      @(negedge clk);
      redirect_rdy = 0;
    end
  endtask

  task automatic test_reset();
    checks++; if (trap_busy !== 0 || redirect_vld !== 0 || wfi_sleep !== 0 || debug_mode !== 0) begin
      errors++; $display("FAIL reset_ctrl busy=%b vld=%b sleep=%b dbg=%b want 0000", trap_busy, redirect_vld, wfi_sleep, debug_mode); end
    checks++; if ({csr_mepc, csr_mtval, csr_dpc, csr_mcause, redirect_pc} !== '0 || csr_mstatus_mie !== 0 || csr_mstatus_mpie !== 0 || trap_drop_err !== 0) begin
      errors++; $display("FAIL reset_csrs mepc=%h mtval=%h dpc=%h mcause=%h rpc=%h want all 0", csr_mepc, csr_mtval, csr_dpc, csr_mcause, redirect_pc); end
  endtask

  task automatic test_ecall();
    logic [31:0] p; int lat; bit st;
    csr_mtvec = 32'h400;
    csr_write(3'd4, 32'h1);
    issue(2'b11, {1'b0, MCAUSE_ECALL_M}, 32'h100, 32'h73, 0, p, lat, st);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ecall_latency got=%0d want=2", lat); end
    checks++; if (p !== 32'h400) begin errors++; $display("FAIL ecall_pc got=%h want=400", p); end
    checks++; if (csr_mepc !== 32'h100 || csr_mcause !== 32'd11) begin
      errors++; $display("FAIL ecall_csr mepc=%h mcause=%h want 100/b", csr_mepc, csr_mcause); end
    checks++; if (csr_mstatus_mie !== 0 || csr_mstatus_mpie !== 1) begin
      errors++; $display("FAIL ecall_mstatus mie=%b mpie=%b want 0/1", csr_mstatus_mie, csr_mstatus_mpie); end
    checks++; if (trap_busy !== 0) begin errors++; $display("FAIL ecall_idle_n3 busy=%b want 0", trap_busy); end
  endtask

  task automatic test_vectored_irq();
    logic [31:0] p; int lat; bit st;
    csr_mtvec = 32'h401;
    issue(2'b11, {1'b1, 5'd7}, 32'h180, 32'h0, 1, p, lat, st);
    checks++; if (p !== 32'h41C) begin errors++; $display("FAIL irq_vector_pc got=%h want=41c", p); end
    checks++; if (csr_mcause !== 32'h8000_0007 || csr_mtval !== 0) begin
      errors++; $display("FAIL irq_csr mcause=%h mtval=%h want 80000007/0", csr_mcause, csr_mtval); end
  endtask

  task automatic test_illegal_mret();
    logic [31:0] p; int lat; bit st;
    csr_mtvec = 32'h400;
    csr_write(3'd4, 32'h1);
    issue(2'b11, {1'b0, MCAUSE_ILLEGAL_INSTR}, 32'h200, 32'hFFFF_FFFF, 0, p, lat, st);
    checks++; if (csr_mtval !== 32'hFFFF_FFFF || p !== 32'h400) begin
      errors++; $display("FAIL illegal_trap mtval=%h pc=%h want ffffffff/400", csr_mtval, p); end
    issue(2'b01, 6'd0, 32'h404, 32'h0, 3, p, lat, st);
    checks++; if (p !== 32'h200 || st !== 1) begin
      errors++; $display("FAIL mret_hold pc=%h stable=%b want 200/1", p, st); end
    checks++; if (csr_mstatus_mie !== 1 || csr_mstatus_mpie !== 1) begin
      errors++; $display("FAIL mret_mstatus mie=%b mpie=%b want 1/1", csr_mstatus_mie, csr_mstatus_mpie); end
  endtask

  task automatic test_debug();
    logic [31:0] p, mepc0; int lat; bit st;
    mepc0 = csr_mepc;
    issue(2'b11, DEBUG_HALT_REQ, 32'h300, 32'h0, 0, p, lat, st);
    checks++; if (debug_mode !== 1 || csr_dpc !== 32'h300 || p !== 32'h800 || csr_mepc !== mepc0) begin
      errors++; $display("FAIL debug_entry dbg=%b dpc=%h pc=%h mepc=%h want 1/300/800/%h", debug_mode, csr_dpc, p, csr_mepc, mepc0); end
    issue(2'b11, {1'b0, MCAUSE_BREAK}, 32'h804, 32'h0, 0, p, lat, st);
    checks++; if (p !== 32'h800 || csr_mepc !== mepc0) begin
      errors++; $display("FAIL debug_trap pc=%h mepc=%h want 800/%h", p, csr_mepc, mepc0); end
    issue(2'b10, 6'd0, 32'h808, 32'h0, 0, p, lat, st);
    checks++; if (p !== 32'h300 || debug_mode !== 0) begin
      errors++; $display("FAIL dret pc=%h dbg=%b want 300/0", p, debug_mode); end
    issue(2'b10, 6'd0, 32'h308, 32'h7B20_0073, 0, p, lat, st);
    checks++; if (p !== 32'h400 || csr_mepc !== 32'h308 || csr_mcause !== 32'd2 || csr_mtval !== 32'h7B20_0073) begin
      errors++; $display("FAIL dret_illegal pc=%h mepc=%h mcause=%h mtval=%h want 400/308/2/7b200073", p, csr_mepc, csr_mcause, csr_mtval); end
  endtask

  task automatic test_csr_write();
    @(negedge clk);
    spu_jump_vld = 1; spu_jump_op = 2'b00; csr_sepc = 32'h500;
    csr_wr_vld = 1; csr_wr_sel = 3'd3; csr_wr_data = 32'hABCD_0000;
    @(negedge clk);
    spu_jump_vld = 0; csr_wr_data = 32'h1111_1111;
    @(negedge clk);
    csr_wr_sel = 3'd0; redirect_rdy = 1;
    @(negedge clk);
    csr_wr_vld = 0; redirect_rdy = 0;
    checks++; if (csr_dpc !== 32'hABCD_0000 || csr_mepc !== 32'h308) begin
      errors++; $display("FAIL csr_write_gate dpc=%h mepc=%h want abcd0000/308", csr_dpc, csr_mepc); end
    csr_write(3'd1, 32'hFFFF_FFFF);
    checks++; if (csr_mcause !== 32'h8000_001F) begin
      errors++; $display("FAIL csr_write_mcause got=%h want 8000001f", csr_mcause); end
  endtask

  task automatic test_wfi(input int delay, input bit poke);
    int cnt; bit done;
    @(negedge clk);
    spu_wfi_vld = 1;
    if (delay == 1) irq_pending = 1;
    @(negedge clk);
    spu_wfi_vld = 0;
    cnt = 0; done = 0;
    for (int i = 1; i <= 40; i++) begin
      spu_jump_vld = (poke && i == 4);
      if (!wfi_sleep) begin done = 1; break; end
      cnt++;
      if (i == delay) irq_pending = 1;
      @(negedge clk);
    end
    spu_jump_vld = 0; irq_pending = 0;
    checks++; if (cnt !== delay || done !== 1) begin
      errors++; $display("FAIL wfi_length delay=%0d got=%0d want=%0d", delay, cnt, delay); end
    @(negedge clk);
    checks++; if (trap_busy !== 0 || redirect_vld !== 0) begin
      errors++; $display("FAIL wfi_exit busy=%b vld=%b want 0/0", trap_busy, redirect_vld); end
    if (poke) begin
      checks++; if (trap_drop_err !== 1) begin errors++; $display("FAIL wfi_drop_err got=%b want 1", trap_drop_err); end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] p, tgt, pc, inst; int lat; bit st;
    logic [1:0] op; logic [5:0] cause; int dly;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [2:0] sel; logic [31:0] d;
        sel = 3'($urandom_range(0, 4)); d = $urandom;
        csr_write(sel, d);
        model_write(sel, d);
      end
      op = 2'($urandom_range(0, 3));
      cause = ($urandom_range(0, 7) == 0) ? DEBUG_HALT_REQ : 6'($urandom);
      pc = $urandom & 32'hFFFF_FFFC; inst = $urandom;
      csr_mtvec = $urandom; csr_sepc = $urandom & 32'hFFFF_FFFC;
      dly = $urandom_range(0, 2);
      model_req(op, cause, pc, inst, csr_mtvec, csr_sepc, tgt);
      issue(op, cause, pc, inst, dly, p, lat, st);
      checks++; if (p !== tgt || lat !== 2 || st !== 1) begin
        errors++; $display("FAIL rand_redirect k=%0d op=%0d cause=%h pc=%h lat=%0d st=%b want pc=%h lat=2", k, op, cause, p, lat, st, tgt); end
      checks++; if (csr_mepc !== m_mepc || csr_mcause !== m_mcause || csr_mtval !== m_mtval || csr_dpc !== m_dpc) begin
        errors++; $display("FAIL rand_csr k=%0d mepc=%h mcause=%h mtval=%h dpc=%h want %h %h %h %h", k, csr_mepc, csr_mcause, csr_mtval, csr_dpc, m_mepc, m_mcause, m_mtval, m_dpc); end
      checks++; if (csr_mstatus_mie !== m_mie || csr_mstatus_mpie !== m_mpie || debug_mode !== m_dbg || trap_busy !== 0) begin
        errors++; $display("FAIL rand_status k=%0d mie=%b mpie=%b dbg=%b busy=%b want %b %b %b 0", k, csr_mstatus_mie, csr_mstatus_mpie, debug_mode, trap_busy, m_mie, m_mpie, m_dbg); end
    end
  endtask

  task automatic test_reset_mid_redirect();
    bit seen;
    @(negedge clk);
    spu_jump_vld = 1; spu_jump_op = 2'b11; spu_trap_cause = 6'd11; spu_trap_pc = 32'h140;
    @(negedge clk);
    spu_jump_vld = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (redirect_vld) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL rst_setup_redirect got=%b want 1", seen); end
    rst = 1;
    #1;
    checks++; if (redirect_vld !== 0 || trap_busy !== 0 || trap_drop_err !== 0 || debug_mode !== 0) begin
      errors++; $display("FAIL rst_async vld=%b busy=%b drop=%b dbg=%b want 0000", redirect_vld, trap_busy, trap_drop_err, debug_mode); end
    checks++; if ({csr_mepc, csr_mtval, csr_dpc, csr_mcause, redirect_pc} !== '0 || csr_mstatus_mie !== 0 || csr_mstatus_mpie !== 0) begin
      errors++; $display("FAIL rst_csrs mepc=%h mcause=%h dpc=%h want all 0", csr_mepc, csr_mcause, csr_dpc); end
    @(negedge clk); rst = 0;
    @(negedge clk); spu_wfi_vld = 1;
    @(negedge clk); spu_wfi_vld = 0;
    rst = 1;
    #1;
    checks++; if (wfi_sleep !== 0 || trap_busy !== 0) begin
      errors++; $display("FAIL rst_wfi sleep=%b busy=%b want 0/0", wfi_sleep, trap_busy); end
    @(negedge clk); rst = 0;
    model_reset();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 0;
    test_ecall();
    test_vectored_irq();
    test_illegal_mret();
    test_debug();
    test_csr_write();
    test_wfi(10, 1'b1);
    test_wfi(1, 1'b0);
    test_wfi(int'($urandom_range(2, 6)), 1'b0);
    test_reset_mid_redirect();
    test_random(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
